bip_control_unit: RTL and testbench

//  Single-cycle sequencer for the BIP core. Holds the program counter that addresses

---
 rtl/bip_control_unit.sv | 112 +++++++++++
 tb/tb_bip_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// BIP core sequencer: program counter, instruction decode and start/halt run control.
// Controls are decoded combinationally from instr and are only active while running.
module bip_control_unit #(
   parameter int PC_WIDTH    = 11,
   parameter int PROG_DEPTH  = 10,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [15:0]            instr,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [10:0]            operand,
   output logic                   wr_ram,
   output logic                   rd_ram,
   output logic [1:0]             sel_a,
   output logic                   sel_b,
   output logic                   op,
   output logic                   wr_acc,
   output logic                   busy,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] cycle_count
);

   // state  | meaning
   // S_IDLE | after reset, pc parked at 0, waiting for start
   // S_RUN  | executing one instruction per cycle
   // S_HALT | stopped by HLT or end of program, start restarts at pc 0
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   localparam logic [4:0]          OP_HLT  = 5'd0;
   localparam logic [4:0]          OP_STO  = 5'd1;
   localparam logic [4:0]          OP_LD   = 5'd2;
   localparam logic [4:0]          OP_LDI  = 5'd3;
   localparam logic [4:0]          OP_ADD  = 5'd4;
   localparam logic [4:0]          OP_ADDI = 5'd5;
   localparam logic [4:0]          OP_SUB  = 5'd6;
   localparam logic [4:0]          OP_SUBI = 5'd7;
   localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_DEPTH - 1);

   state_t     state, state_nxt;
   logic [4:0] opcode;
   logic       stop_run;

   assign opcode   = instr[15:11];
   // The last program word still executes, but pc never wraps back to 0.
   assign stop_run = (opcode == OP_HLT) || (pc == LAST_PC);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (stop_run) state_nxt = S_HALT;
         S_HALT:  if (start) state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= '0;
      end else begin
         case (state)
            S_RUN:   if (!stop_run) pc <= pc + PC_WIDTH'(1);
            S_HALT:  if (start) pc <= '0;
            default: pc <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_count <= '0;
      end else begin
         case (state)
            S_RUN:   if (cycle_count != '1) cycle_count <= cycle_count + COUNT_WIDTH'(1);
            default: if (start) cycle_count <= '0;
         endcase
      end
   end

   always_comb begin
      wr_ram = 1'b0;
      rd_ram = 1'b0;
      sel_a  = 2'b00;
      sel_b  = 1'b0;
      op     = 1'b0;
      wr_acc = 1'b0;
      if (state == S_RUN) begin
         case (opcode)
            OP_STO:  wr_ram = 1'b1;
            OP_LD:   begin rd_ram = 1'b1; sel_a = 2'b00; wr_acc = 1'b1; end
            OP_LDI:  begin sel_a = 2'b01; wr_acc = 1'b1; end
            OP_ADD:  begin rd_ram = 1'b1; sel_a = 2'b10; wr_acc = 1'b1; end
            OP_ADDI: begin sel_a = 2'b10; sel_b = 1'b1; wr_acc = 1'b1; end
            OP_SUB:  begin rd_ram = 1'b1; sel_a = 2'b10; op = 1'b1; wr_acc = 1'b1; end
            OP_SUBI: begin sel_a = 2'b10; sel_b = 1'b1; op = 1'b1; wr_acc = 1'b1; end
            default: ;
         endcase
      end
   end

   assign operand = instr[10:0];
   assign busy    = (state == S_RUN);
   assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_bip_control_unit.sv
// Directed bench for bip_control_unit: default instance plus a small-counter, deep-program instance.
module tb_bip_control_unit;

   localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3, ADDI = 5'd5;

   logic        clk, reset, start, start2;
   logic [15:0] instr, instr2;
   logic [15:0] prog [32];

   logic [10:0] pc, operand, pc2, operand2;
   logic        wr_ram, rd_ram, sel_b, op, wr_acc, busy, halted;
   logic [1:0]  sel_a, sel_a2;
   logic [15:0] cycle_count;
   logic        wr_ram2, rd_ram2, sel_b2, op2, wr_acc2, busy2, halted2;
   logic [3:0]  cycle_count2;

   int n_vec = 0;
   int n_err = 0;

   bip_control_unit dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr),
      .pc(pc), .operand(operand), .wr_ram(wr_ram), .rd_ram(rd_ram),
      .sel_a(sel_a), .sel_b(sel_b), .op(op), .wr_acc(wr_acc),
      .busy(busy), .halted(halted), .cycle_count(cycle_count)
   );

   bip_control_unit #(.PC_WIDTH(11), .PROG_DEPTH(20), .COUNT_WIDTH(4)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .instr(instr2),
      .pc(pc2), .operand(operand2), .wr_ram(wr_ram2), .rd_ram(rd_ram2),
      .sel_a(sel_a2), .sel_b(sel_b2), .op(op2), .wr_acc(wr_acc2),
      .busy(busy2), .halted(halted2), .cycle_count(cycle_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb instr = prog[pc[4:0]];
   assign instr2 = {LDI, 11'd7};

   function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
      return {o, a};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // {wr_ram, rd_ram, sel_a, sel_b, op, wr_acc}
   function automatic logic [31:0] ctl();
      return {25'd0, wr_ram, rd_ram, sel_a, sel_b, op, wr_acc};
   endfunction

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      start2 = 1'b0;
      for (int i = 0; i < 32; i++) prog[i] = ins(LDI, 11'(i));

      #12;
      check("rst_pc", pc, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_count", cycle_count, 0);
      check("rst_ctl", ctl(), 0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      check("idle_ctl", ctl(), 0);
      check("idle_pc", pc, 0);

      // Program 1: LDI 16, STO 1, LD 1, ADDI 255, STO 2, LD 2, HLT
      prog[0] = ins(LDI, 11'd16);
      prog[1] = ins(STO, 11'd1);
      prog[2] = ins(LD, 11'd1);
      prog[3] = ins(ADDI, 11'd255);
      prog[4] = ins(STO, 11'd2);
      prog[5] = ins(LD, 11'd2);
      prog[6] = ins(HLT, 11'd0);
      pulse_start();
      check("p1_pc0", pc, 0);
      check("p1_busy", busy, 1);
      check("p1_ctl0_ldi", ctl(), 32'b0_0_01_0_0_1);
      check("p1_operand0", operand, 16);
      @(negedge clk);
      check("p1_pc1", pc, 1);
      check("p1_ctl1_sto", ctl(), 32'b1_0_00_0_0_0);
      @(negedge clk);
      check("p1_ctl2_ld", ctl(), 32'b0_1_00_0_0_1);
      @(negedge clk);
      check("p1_pc3", pc, 3);
      check("p1_ctl3_addi", ctl(), 32'b0_0_10_1_0_1);
      check("p1_operand3", operand, 255);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("p1_pc6", pc, 6);
      check("p1_ctl6_hlt", ctl(), 0);
      check("p1_busy6", busy, 1);
      @(negedge clk);
      check("p1_halted", halted, 1);
      check("p1_busy_off", busy, 0);
      check("p1_pc_end", pc, 6);
      check("p1_count", cycle_count, 7);
      check("p1_halt_ctl", ctl(), 0);
      @(negedge clk);
      check("p1_pc_hold", pc, 6);

      // Undefined opcode runs as NOP; start held in RUN is ignored; restart from HALT.
      prog[0] = 16'h5000;
      prog[1] = ins(LDI, 11'd4);
      prog[2] = ins(HLT, 11'd0);
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      check("nop_restart_pc", pc, 0);
      check("nop_restart_cnt", cycle_count, 0);
      check("nop_busy", busy, 1);
      check("nop_ctl", ctl(), 0);
      @(negedge clk);
      check("hold_start_pc", pc, 1);
      check("hold_start_cnt", cycle_count, 1);
      start = 1'b0;
      @(negedge clk);
      check("p2_pc2", pc, 2);
      @(negedge clk);
      check("p2_halted", halted, 1);
      check("p2_pc", pc, 2);
      check("p2_count", cycle_count, 3);

      // No HLT: run to the last program word, then halt without wrapping.
      for (int i = 0; i < 32; i++) prog[i] = ins(LDI, 11'(i));
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         check("p3_pc", pc, 32'(i));
         if (i < 9) @(negedge clk);
      end
      @(negedge clk);
      check("p3_halted", halted, 1);
      check("p3_pc_end", pc, 9);
      check("p3_count", cycle_count, 10);

      // Async reset mid-run.
      pulse_start();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("p4_pc3", pc, 3);
      #2 reset = 1'b0;
      #1;
      check("p4_rst_pc", pc, 0);
      check("p4_rst_busy", busy, 0);
      check("p4_rst_count", cycle_count, 0);
      check("p4_rst_ctl", ctl(), 0);
      @(negedge clk) reset = 1'b1;
      pulse_start();
      check("p4_run_pc", pc, 0);
      check("p4_run_busy", busy, 1);
      @(negedge clk);
      check("p4_run_pc1", pc, 1);

      // Narrow counter saturates at 15; deep program halts at pc 19.
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("p6_pc", pc2, 32'(i));
         check("p6_count", cycle_count2, (i > 15) ? 15 : i);
         @(negedge clk);
      end
      check("p6_halted", halted2, 1);
      check("p6_pc_end", pc2, 19);
      check("p6_count_end", cycle_count2, 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
